// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial bit-pattern detector with registered one-cycle hit flag (optional SEQ_DETECTOR_HIT_COUNT_EN adds hit_count)
module seq_detector #(
    parameter int                 SEQ_LEN = 4,
    parameter logic [SEQ_LEN-1:0] SEQ     = 4'b1010,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d,
    output logic        Z
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
    ,
    output logic [15:0] hit_count
`endif
);

    localparam int               CW   = $clog2(SEQ_LEN + 1);
    localparam logic [CW-1:0]    FULL = CW'(SEQ_LEN);

    logic [SEQ_LEN-1:0] hist;
    logic [SEQ_LEN-1:0] hist_next;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;
    logic               hit;

    // Next history and saturating fill count; the fill gate keeps reset-value history from matching
    always_comb begin
        hist_next = {hist[SEQ_LEN-2:0], d};
        cnt_inc   = (cnt == FULL) ? FULL : cnt + 1'b1;
        hit       = (hist_next == SEQ) && (cnt_inc == FULL);
    end

    // Shift in one bit per edge; in non-overlap mode a hit restarts the fill count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            cnt  <= '0;
            Z    <= 1'b0;
        end else begin
            hist <= hist_next;
            cnt  <= (hit && !OVERLAP) ? '0 : cnt_inc;
            Z    <= hit;
        end
    end

`ifdef SEQ_DETECTOR_HIT_COUNT_EN
    // Count detections, wrapping at 16 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count <= '0;
        end else if (hit) begin
            hit_count <= hit_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector against a bit-history reference model
module tb_seq_detector;

    logic       clk;
    logic       reset;
    logic       d;
    logic [3:0] zv;
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
    logic [15:0] hc [4];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration mirrored in the model
    int          len [4] = '{4, 4, 4, 5};
    logic [15:0] pat [4] = '{16'hA, 16'hA, 16'h0, 16'h1B};
    bit          ovl [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    bit     q [4][$];
    logic   exp_z [4];
    int     hits [4];

    seq_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b1)) u0 (
        .clk(clk), .reset(reset), .d(d), .Z(zv[0])
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        , .hit_count(hc[0])
`endif
    );
    seq_detector #(.SEQ_LEN(4), .SEQ(4'b1010), .OVERLAP(1'b0)) u1 (
        .clk(clk), .reset(reset), .d(d), .Z(zv[1])
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        , .hit_count(hc[1])
`endif
    );
    seq_detector #(.SEQ_LEN(4), .SEQ(4'b0000), .OVERLAP(1'b1)) u2 (
        .clk(clk), .reset(reset), .d(d), .Z(zv[2])
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        , .hit_count(hc[2])
`endif
    );
    seq_detector #(.SEQ_LEN(5), .SEQ(5'b11011), .OVERLAP(1'b1)) u3 (
        .clk(clk), .reset(reset), .d(d), .Z(zv[3])
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        , .hit_count(hc[3])
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            q[k].delete();
            exp_z[k] = 1'b0;
            hits[k]  = 0;
        end
    endtask

    // Drive one bit, let the edge sample it, update the model, settle 1 time unit past the edge
    task automatic step(input logic b);
        bit m;
        d = b;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            q[k].push_back(b);
            if (q[k].size() > 16) void'(q[k].pop_front());
            m = (q[k].size() >= len[k]);
            if (m) begin
                for (int i = 0; i < len[k]; i++) begin
                    if (q[k][q[k].size() - 1 - i] != pat[k][i]) m = 1'b0;
                end
            end
            exp_z[k] = m;
            if (m) hits[k] = (hits[k] + 1) & 16'hFFFF;
            if (m && !ovl[k]) q[k].delete();
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            d = c[0];
            @(posedge clk);
            #1;
            n_checks++;
            if (zv !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: Z=%b expected 0000", c, zv);
            end
        end
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        n_checks++;
        if (hc[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: hit_count=%0d expected 0", hc[0]);
        end
`endif
        model_reset();
        reset = 1'b1;
        step(1); step(0); step(1); step(0);
        n_checks++;
        if (zv[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_pre: Z=%b expected 1", zv[0]);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (zv !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: Z=%b expected 0000 without clock edge", zv);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0] bits = 5'b10101;
        logic [4:0] want = 5'b00010;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(bits[4-i]);
            n_checks++;
            if (zv[0] !== want[4-i] || zv[0] !== exp_z[0]) begin
                n_fail++;
                $display("FAIL basic bit %0d: Z=%b expected %b", i + 1, zv[0], want[4-i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] w0   = 6'b000101;
        logic [5:0] w1   = 6'b000100;
        int p0 = 0;
        int p1 = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(bits[5-i]);
            p0 += int'(zv[0]);
            p1 += int'(zv[1]);
            n_checks++;
            if (zv[0] !== w0[5-i] || zv[1] !== w1[5-i]) begin
                n_fail++;
                $display("FAIL overlap bit %0d: Z(ov,nov)=%b%b expected %b%b", i + 1, zv[0], zv[1], w0[5-i], w1[5-i]);
            end
        end
        n_checks++;
        if (p0 != 2 || p1 != 1) begin
            n_fail++;
            $display("FAIL overlap_pulses: got %0d/%0d expected 2/1", p0, p1);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits = 4'b1010;
        do_reset();
        step(1); step(0); step(1);
        do_reset();
        step(0);
        n_checks++;
        if (zv[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_span: Z=%b expected 0", zv[0]);
        end
        for (int i = 0; i < 4; i++) begin
            step(bits[3-i]);
            n_checks++;
            if (zv[0] !== (i == 3) || zv[0] !== exp_z[0]) begin
                n_fail++;
                $display("FAIL reset_mid bit %0d: Z=%b expected %b", i + 1, zv[0], (i == 3));
            end
        end
    endtask

    task automatic test_startup();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(0);
            n_checks++;
            if (zv[2] !== (i >= 3) || zv[2] !== exp_z[2]) begin
                n_fail++;
                $display("FAIL startup bit %0d: Z=%b expected %b", i + 1, zv[2], (i >= 3));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(i == 2 ? 1'b0 : 1'b1);
            n_checks++;
            if (zv[3] !== exp_z[3]) begin
                n_fail++;
                $display("FAIL back_to_back bit %0d: Z=%b expected %b", i + 1, zv[3], exp_z[3]);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int s = 0; s < 600; s++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            step(1'($urandom_range(0, 1)));
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (zv[k] !== exp_z[k]) begin
                    n_fail++;
                    $display("FAIL random step %0d inst %0d: Z=%b expected %b", s, k, zv[k], exp_z[k]);
                end
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
                n_checks++;
                if (hc[k] !== 16'(hits[k])) begin
                    n_fail++;
                    $display("FAIL random_count step %0d inst %0d: hit_count=%0d expected %0d", s, k, hc[k], hits[k]);
                end
`endif
            end
        end
    endtask

`ifdef SEQ_DETECTOR_HIT_COUNT_EN
    task automatic test_counter();
        logic [7:0] bits = 8'b10101010;
        do_reset();
        for (int i = 0; i < 8; i++) step(bits[7-i]);
        n_checks++;
        if (hc[0] !== 16'd3) begin
            n_fail++;
            $display("FAIL counter_final: hit_count=%0d expected 3", hc[0]);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (hc[0] !== 16'd0) begin
            n_fail++;
            $display("FAIL counter_reset: hit_count=%0d expected 0", hc[0]);
        end
        @(posedge clk);
        #1;
        model_reset();
        reset = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b0;
        d     = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_reset_mid();
        test_startup();
        test_back_to_back();
`ifdef SEQ_DETECTOR_HIT_COUNT_EN
        test_counter();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
